// File: rtl/pwm_hbridge_driver.sv
// Signed duty word to complementary H-bridge PWM with clamping, boundary-synchronous update and
// dead time on reversal. Define PWM_SLEW_LIMIT_EN to rate-limit the applied duty per period.
module pwm_hbridge_driver #(
  parameter int PERIOD    = 2500,
  parameter int DEAD_TIME = 50,
  parameter int SLEW_STEP = 100
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] duty_in,
  input  logic        duty_valid,
  output logic        pwm_a,
  output logic        pwm_b,
  output logic        direction,
  output logic        period_start,
  output logic [31:0] duty_applied
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic signed [31:0] PMax = 32'(PERIOD);
  localparam logic signed [31:0] PMin = -32'(PERIOD);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e             r_state;
  logic [CW-1:0]      r_counter;
  logic [DW-1:0]      r_dead_cnt;
  logic signed [31:0] r_target;
  logic signed [31:0] r_active;
  logic               r_last_neg;
  logic               r_pwm_a;
  logic               r_pwm_b;
  logic               r_period_start;

  state_e             w_state_nxt;
  logic [CW-1:0]      w_counter_nxt;
  logic [DW-1:0]      w_dead_nxt;
  logic signed [31:0] w_active_nxt;
  logic               w_last_neg_nxt;
  logic signed [31:0] w_clamp;
  logic signed [31:0] w_next_target;
  logic signed [31:0] w_load;
  logic               w_boundary;
  logic               w_reversal;
  logic [31:0]        w_mag;
  logic               w_on;

  always_comb begin
    w_clamp = $signed(duty_in);
    if ($signed(duty_in) > PMax) w_clamp = PMax;
    else if ($signed(duty_in) < PMin) w_clamp = PMin;
  end

  assign w_boundary    = (r_counter == CW'(PERIOD - 1));
  assign w_counter_nxt = w_boundary ? '0 : r_counter + CW'(1);
  // A strobe on the boundary cycle itself overrides the held target.
  assign w_next_target = duty_valid ? w_clamp : r_target;

`ifdef PWM_SLEW_LIMIT_EN
  localparam logic signed [31:0] Slew = 32'(SLEW_STEP);
  logic signed [31:0] w_delta;
  logic signed [31:0] w_step;
  assign w_delta = w_next_target - r_active;
  assign w_step  = (w_delta > Slew) ? Slew : ((w_delta < -Slew) ? -Slew : w_delta);
  assign w_load  = r_active + w_step;
`else
  logic w_unused_slew;
  assign w_unused_slew = ^32'(SLEW_STEP);
  assign w_load        = w_next_target;
`endif

  // Zero never updates the remembered sign, so +, 0, - still counts as a reversal.
  assign w_reversal = (w_load != 32'sd0) && (w_load[31] != r_last_neg);

  always_comb begin
    w_state_nxt    = r_state;
    w_active_nxt   = r_active;
    w_dead_nxt     = r_dead_cnt;
    w_last_neg_nxt = r_last_neg;
    if (!enable) begin
      w_state_nxt  = StIdle;
      w_active_nxt = 32'sd0;
      w_dead_nxt   = '0;
    end else begin
      if (r_state == StDead) begin
        w_dead_nxt = r_dead_cnt - DW'(1);
        if (w_dead_nxt == '0) w_state_nxt = StRun;
      end
      if (w_boundary) begin
        w_active_nxt = w_load;
        if (w_load != 32'sd0) w_last_neg_nxt = w_load[31];
        if (w_reversal && (DEAD_TIME > 0)) begin
          w_state_nxt = StDead;
          w_dead_nxt  = DW'(DEAD_TIME);
        end else if (r_state == StIdle) begin
          w_state_nxt = StRun;
        end
      end
    end
  end

  // Gates are registered from next-state values so the counter==0 cycle uses the new duty.
  assign w_mag = w_active_nxt[31] ? 32'(-w_active_nxt) : 32'(w_active_nxt);
  assign w_on  = (w_state_nxt == StRun) && (32'(w_counter_nxt) < w_mag);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_counter      <= '0;
      r_dead_cnt     <= '0;
      r_target       <= 32'sd0;
      r_active       <= 32'sd0;
      r_last_neg     <= 1'b0;
      r_pwm_a        <= 1'b0;
      r_pwm_b        <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_counter      <= w_counter_nxt;
      r_dead_cnt     <= w_dead_nxt;
      r_active       <= w_active_nxt;
      r_last_neg     <= w_last_neg_nxt;
      r_pwm_a        <= w_on && !w_active_nxt[31];
      r_pwm_b        <= w_on && w_active_nxt[31];
      r_period_start <= (w_counter_nxt == '0);
      if (duty_valid) r_target <= w_clamp;
    end
  end

  assign pwm_a        = r_pwm_a;
  assign pwm_b        = r_pwm_b;
  assign direction    = r_active[31];
  assign period_start = r_period_start;
  assign duty_applied = r_active;

endmodule

// File: doc/pwm_hbridge_driver.md
Name: pwm_hbridge_driver

Overview:
- Downstream consumer of the PID controller's integer output (result_integer).
- Converts a signed duty word into complementary H-bridge PWM gate signals. Adds clamping, period-synchronous duty update, dead-time on direction reversal, and an optional slew limit.
- Emits a period-start strobe that the motor channel uses as the controller's update_controller tick.

Parameters:
- PERIOD, 2500, PWM period in clock cycles; counter runs 0..PERIOD-1; also the full-scale duty magnitude.
- DEAD_TIME, 50, cycles both gates are held low after a direction reversal; must be < PERIOD.
- SLEW_STEP, 100, maximum change of applied duty per period (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  bridge enable; low forces the outputs off
- duty_in  in  32  signed two's-complement duty, in counts of PERIOD
- duty_valid  in  1  one-cycle strobe qualifying duty_in
- pwm_a  out  1  high-side gate, forward direction
- pwm_b  out  1  high-side gate, reverse direction
- direction  out  1  1 = reverse; sign of the applied duty
- period_start  out  1  one-cycle pulse when counter == 0
- duty_applied  out  32  signed duty currently in effect

Behaviour:
- Reset (reset_n low, asynchronous):
  - counter, target, active, dead_cnt all 0; state IDLE.
  - pwm_a, pwm_b, direction, period_start all 0; duty_applied 0.
- Clamp:
  - On duty_valid, target <= duty_in clamped to [-PERIOD, +PERIOD], using a 32-bit signed compare.
  - duty_valid is accepted on any cycle. The last value before a boundary wins.
- Counter:
  - Free-running 0..PERIOD-1, wraps to 0.
  - period_start is registered and high for exactly one cycle each period, while counter==0. It runs in every state, including IDLE.
- Boundary load (cycle where counter==PERIOD-1):
  - active <= next_target, where next_target = clamp(duty_in) if duty_valid is high on that same cycle, else target. The same-cycle strobe takes precedence.
  - duty_applied and direction update together with active.
- State machine:
  - IDLE: outputs low; active forced 0. Leaves to RUN at the first boundary where enable is high.
  - RUN: magnitude m = |active|. The gate on the sign side is high while counter < m; the other gate is low.
    - m == 0 gives both gates low.
    - m == PERIOD gives 100% (continuous high).
  - DEAD: entered at a boundary when the new active has the opposite sign to the last nonzero sign. Zero does not reset the last nonzero sign, so a +to-0-to-minus sequence still triggers DEAD.
    - dead_cnt is loaded with DEAD_TIME; both gates are low while dead_cnt != 0.
    - Returns to RUN when dead_cnt reaches 0, mid-period, with the new-side gate resuming per the counter < m rule.
  - A reversal that arrives while in DEAD reloads dead_cnt.
- Enable:
  - enable low in any state: gates go low on the next edge (registered), active <= 0, state <= IDLE. The counter keeps running.
  - Re-enable waits for the next boundary.
- Gate safety: pwm_a and pwm_b are never high in the same cycle, under all conditions. The bench asserts this on every cycle.
- Latency:
  - duty_in to gate: takes effect at the next counter==0, plus one registered cycle.
  - The counter==0 cycle itself is driven from the just-loaded active.
- Reset mid-period: all outputs go low immediately. After release, counting restarts from 0 in IDLE.

Optional Feature:
- Macro PWM_SLEW_LIMIT_EN.
- Defined: at each boundary, active moves toward next_target by at most SLEW_STEP, computed as active + sat(next_target - active, ±SLEW_STEP).
  - Reversal detection uses the stepped value, so DEAD triggers only when the ramp crosses zero.
  - enable low still forces active to 0 instantly.
- Undefined: active <= next_target directly; SLEW_STEP is unused.

Test Plan (PERIOD=100, DEAD_TIME=5, SLEW_STEP=10):
- Reset release, enable=1, duty_in=+40 strobed -> period_start every 100 cycles; from the next period, pwm_a high 40 cycles/period, pwm_b 0, direction 0, duty_applied=40.
- duty_in=+250, then -7000 -> duty_applied clamps to +100 (pwm_a continuous high), then -100 (pwm_b continuous high, direction 1).
- Applied +60, then -30 strobed -> in the next period both gates low for cycles 0..4; pwm_b high for cycles 5..29; pwm_a never high in that period.
- duty_valid with +20 on the counter==99 cycle, and +80 strobed earlier in the same period -> the next period uses 20; enable dropped mid-period -> gates low on the next edge, duty_applied=0, resumes only after the next boundary.
- reset_n asserted at counter=37 with pwm_a high -> pwm_a, period_start and duty_applied go 0 immediately; no overlap of pwm_a and pwm_b at any point.
- With PWM_SLEW_LIMIT_EN, applied 0, strobe +35 -> duty_applied 10, 20, 30, 35 on successive periods. Then strobe -15 -> duty_applied 25, 15, 5, -5 on successive periods, with DEAD only at the -5 period.
